frame_serializer: RTL and testbench

//   Parallel-to-serial converter that drives the single-bit input of the serial sequence detector.
//   - Accepts WIDTH-bit words over a valid/ready handshake.
//   - Shifts each word out one bit per clk cycle.
//   - A one-word holding register gives gapless back-to-back frames.
//   - Between frames the line sits at IDLE_BIT.

---
 rtl/frame_serializer.sv | 135 +++++++++++++
 tb/tb_frame_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_serializer.sv
// frame_serializer: parallel-to-serial shifter with a one-word holding register.
// Optional even parity bit after each word: FRAME_SERIALIZER_PARITY_EN.
module frame_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] ld_word;
  logic             hold_full;
  logic             accept;
  logic             free;
  logic             load;
  logic             bypass;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(
    input logic [WIDTH-1:0] w
  );
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0}
                            : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = ~hold_full & ~reset;
  assign accept     = load_valid & load_ready;
  assign free       = (state == IDLE) ||
                      (state == SHIFT && bit_cnt == LAST);
  assign load       = free & (hold_full | accept);
  assign bypass     = free & ~hold_full & accept;
  assign ld_word    = hold_full ? hold : load_data;
  assign busy       = (state == SHIFT) | hold_full;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state: stay in SHIFT while words keep arriving at free edges
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // holding register: captures any accepted word that did not bypass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept && !bypass) begin
      hold      <= load_data;
      hold_full <= 1'b1;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

`ifdef FRAME_SERIALIZER_PARITY_EN
  logic par;

  // even parity of the word in flight, sent after the data bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     par <= 1'b0;
    else if (load) par <= ^ld_word;
  end
`endif

  // shifter and registered serial outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (load) begin
      shreg       <= adv(ld_word);
      bit_cnt     <= '0;
      ser_out     <= head(ld_word);
      ser_valid   <= 1'b1;
      frame_start <= 1'b1;
    end else if (state == SHIFT && bit_cnt != LAST) begin
      bit_cnt     <= bit_cnt + CW'(1);
      frame_start <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      if (bit_cnt == CW'(WIDTH - 1)) begin
        ser_out <= par;
      end else begin
        ser_out <= head(shreg);
        shreg   <= adv(shreg);
      end
`else
      ser_out <= head(shreg);
      shreg   <= adv(shreg);
`endif
    end else begin
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed bench with a bit-level scoreboard.
// Parity checks follow FRAME_SERIALIZER_PARITY_EN.
module tb_frame_serializer;

  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;
  logic         busy;

  logic [W-1:0] l_data;
  logic         l_valid;
  logic         l_ready;
  logic         l_ser_out;
  logic         l_ser_valid;
  logic         l_frame_start;
  logic         l_busy;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors;
  int   errs;

  frame_serializer #(
    .WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(IDLE)
  ) u_dut (
    .clk(clk), .reset(reset),
    .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .ser_out(ser_out),
    .ser_valid(ser_valid), .frame_start(frame_start),
    .busy(busy)
  );

  frame_serializer #(
    .WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(IDLE)
  ) u_lsb (
    .clk(clk), .reset(reset),
    .load_data(l_data), .load_valid(l_valid),
    .load_ready(l_ready), .ser_out(l_ser_out),
    .ser_valid(l_ser_valid), .frame_start(l_frame_start),
    .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b  = d[W-1-i];
      e.fs = (i == 0);
      sb.push_back(e);
    end
`ifdef FRAME_SERIALIZER_PARITY_EN
    e.b  = ^d;
    e.fs = 1'b0;
    sb.push_back(e);
`endif
  endtask

  // handshake seen at the edge: the word's bits become expected output
  always @(posedge clk) begin
    if (!reset && load_valid && load_ready) push_word(load_data);
  end

  // compare the serial line against the scoreboard every cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (ser_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          errs++;
          $error("FAIL stray_bit: got valid bit %b want none", ser_out);
        end else begin
          mon_e = sb.pop_front();
          chk("ser_out", 32'(ser_out), 32'(mon_e.b));
          chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
        end
      end else begin
        chk("idle_line", 32'(ser_out), 32'(IDLE));
        chk("idle_fs", 32'(frame_start), 32'd0);
        chk("gap_pending", 32'(sb.size()), 32'd0);
      end
    end
  end

  task automatic offer(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 64; i++) begin
      if (load_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    vectors++;
    errs++;
    $error("FAIL offer_timeout: got no accept want accept of %0h", d);
  endtask

  task automatic idle_cycles(input int n);
    load_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] lw;
    vectors    = 0;
    errs       = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    l_valid    = 1'b0;
    l_data     = '0;

    repeat (2) @(negedge clk);
    chk("rst_ser_out", 32'(ser_out), 32'(IDLE));
    chk("rst_valid", 32'(ser_valid), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);

    // single word from idle
    offer(8'hB0);
    chk("single_busy", 32'(busy), 32'd1);
    idle_cycles(10);
    chk("single_done", 32'(busy), 32'd0);

    // back-to-back words, second lands in the holding register
    offer(8'hA5);
    offer(8'h3C);
    load_valid = 1'b0;
    chk("b2b_ready", 32'(load_ready), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    idle_cycles(22);

    // backpressure: third word waits while hold is full
    offer(8'h11);
    offer(8'h22);
    chk("bp_ready", 32'(load_ready), 32'd0);
    offer(8'h33);
    idle_cycles(34);

    // LSB-first instance
    lw      = 8'h01;
    l_valid = 1'b1;
    l_data  = lw;
    @(negedge clk);
    l_valid = 1'b0;
    l_data  = 8'hFF;
    chk("lsb_fs", 32'(l_frame_start), 32'd1);
    for (int i = 0; i < W; i++) begin
      chk("lsb_valid", 32'(l_ser_valid), 32'd1);
      chk("lsb_bit", 32'(l_ser_out), 32'(lw[i]));
      @(negedge clk);
    end
`ifdef FRAME_SERIALIZER_PARITY_EN
    chk("lsb_par", 32'(l_ser_out), 32'(^lw));
    @(negedge clk);
`endif
    chk("lsb_end", 32'(l_ser_valid), 32'd0);

    // reset mid-frame with the holding register full
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(negedge clk);
    load_data  = 8'h0F;
    @(negedge clk);
    load_valid = 1'b0;
    chk("mid_hold_ready", 32'(load_ready), 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_ser_out", 32'(ser_out), 32'(IDLE));
    chk("mid_valid", 32'(ser_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_fs", 32'(frame_start), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    idle_cycles(20);

    // parity-sized frames back-to-back
    offer(8'h07);
    offer(8'h5A);
    idle_cycles(22);

    // a few random words with random gaps
    for (int k = 0; k < 6; k++) begin
      offer(W'($urandom_range(0, 255)));
      idle_cycles($urandom_range(0, 12));
    end
    idle_cycles(30);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
